// File: rtl/phase_deadtime_guard_if.sv
// Pattern/control bundle between the drive sequencer side and phase_deadtime_guard.
interface phase_deadtime_guard_if;
  logic [3:0] phase_in;
  logic       enable;
  logic       fault;
  logic       fault_clr;
  logic [3:0] phase_out;
  logic       busy;
  logic       fault_latched;
  logic       illegal;

  modport master (
    output phase_in, enable, fault, fault_clr,
    input  phase_out, busy, fault_latched, illegal
  );

  modport slave (
    input  phase_in, enable, fault, fault_clr,
    output phase_out, busy, fault_latched, illegal
  );
endinterface

// File: rtl/phase_deadtime_guard.sv
// Break-before-make output stage for the 4-phase coil drive, with fault/disable forcing.
// Define DT_PAIR_CHECK_EN to mask and flag patterns that energise both bits of a coil pair.
module phase_deadtime_guard #(
  parameter int unsigned DEAD_CYCLES = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  phase_deadtime_guard_if.slave bus
);

  localparam int unsigned CNT_W = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StHold, StDead, StFault} state_e;

  state_e           state_q, state_d;
  logic [3:0]       phase_out_q, phase_out_d;
  logic [3:0]       tgt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [3:0]       tgt;
  logic [3:0]       on_bits;
  logic             start_dead;

`ifdef DT_PAIR_CHECK_EN
  logic illegal_q, illegal_d;
  logic pair_lo_bad, pair_hi_bad;

  always_comb begin
    pair_lo_bad = &bus.phase_in[1:0];
    pair_hi_bad = &bus.phase_in[3:2];
    tgt         = {pair_hi_bad ? 2'b00 : bus.phase_in[3:2],
                   pair_lo_bad ? 2'b00 : bus.phase_in[1:0]};
    illegal_d   = illegal_q | pair_lo_bad | pair_hi_bad;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign tgt         = bus.phase_in;
  assign bus.illegal = 1'b0;
`endif

  assign on_bits = tgt & ~phase_out_q;

  always_comb begin
    state_d     = state_q;
    phase_out_d = phase_out_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    start_dead  = 1'b0;

    if (bus.fault) begin
      state_d     = StFault;
      phase_out_d = 4'b0000;
      fault_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          phase_out_d = 4'b0000;
          start_dead  = bus.enable;
        end
        StHold: begin
          if (!bus.enable) begin
            state_d     = StIdle;
            phase_out_d = 4'b0000;
          end else begin
            phase_out_d = phase_out_q & tgt;
            start_dead  = (on_bits != 4'b0000);
          end
        end
        StDead: begin
          if (!bus.enable) begin
            state_d     = StIdle;
            phase_out_d = 4'b0000;
          end else if (tgt != tgt_q) begin
            // Target moved mid-wait: restart the full dead-time.
            start_dead = 1'b1;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d     = StHold;
            phase_out_d = tgt;
          end else begin
            phase_out_d = phase_out_q & tgt;
            cnt_d       = cnt_q - CNT_W'(1);
          end
        end
        StFault: begin
          phase_out_d = 4'b0000;
          if (bus.fault_clr) begin
            fault_d = 1'b0;
            if (bus.enable) begin
              start_dead = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d     = StIdle;
          phase_out_d = 4'b0000;
        end
      endcase

      // Zero dead-time drives the target straight through and never enters StDead.
      if (start_dead) begin
        if (DEAD_CYCLES == 0) begin
          state_d     = StHold;
          phase_out_d = tgt;
        end else begin
          state_d     = StDead;
          cnt_d       = CNT_W'(DEAD_CYCLES);
          phase_out_d = phase_out_q & tgt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      phase_out_q <= 4'b0000;
      tgt_q       <= 4'b0000;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_out_q <= phase_out_d;
      tgt_q       <= tgt;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.phase_out     = phase_out_q;
  assign bus.busy          = (state_q == StDead);
  assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_phase_deadtime_guard.sv
// Directed bench for phase_deadtime_guard: dead-time 3 instance driven from a vector table,
// plus a zero dead-time instance and hand-written reset/fault sequences.
module tb_phase_deadtime_guard;

`ifdef DT_PAIR_CHECK_EN
  localparam bit PairChk = 1'b1;
`else
  localparam bit PairChk = 1'b0;
`endif

  typedef struct {
    logic [3:0] pi;
    logic       en;
    logic       flt;
    logic       clr;
    logic [3:0] po;
    logic       bsy;
    logic       fl;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   busy0_seen = 1'b0;
  vec_t vecs[$];

  phase_deadtime_guard_if if3 ();
  phase_deadtime_guard_if if0 ();

  phase_deadtime_guard #(.DEAD_CYCLES(3)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3.slave)
  );

  phase_deadtime_guard #(.DEAD_CYCLES(0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) busy0_seen <= busy0_seen | (if0.busy === 1'b1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] pi, input logic en, input logic flt, input logic clr,
                     input logic [3:0] po, input logic bsy, input logic fl, input logic ill);
    vec_t v;
    v.pi = pi; v.en = en; v.flt = flt; v.clr = clr;
    v.po = po; v.bsy = bsy; v.fl = fl; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bcnt;

    // Each row: inputs seen at one rising edge, outputs expected just after it.
    add(4'b0101, 1, 0, 0, 4'b0000, 1, 0, 0); // 0: IDLE -> DEAD after reset
    add(4'b0101, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0101, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0101, 1, 0, 0, 4'b0101, 0, 0, 0); // 3: E+4
    add(4'b0101, 1, 0, 0, 4'b0101, 0, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b0000, 1, 0, 0); // 5: full swap
    add(4'b1010, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b1010, 0, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b1010, 0, 0, 0);
    add(4'b1010, 1, 1, 0, 4'b0000, 0, 1, 0); // 10: fault
    add(4'b1010, 1, 1, 1, 4'b0000, 0, 1, 0); // clear ignored under fault
    add(4'b1010, 1, 1, 0, 4'b0000, 0, 1, 0);
    add(4'b1010, 1, 0, 0, 4'b0000, 0, 1, 0); // sticky without clear
    add(4'b1010, 1, 0, 1, 4'b0000, 1, 0, 0); // 14: cleared -> DEAD
    add(4'b1010, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b1010, 1, 0, 0, 4'b1010, 0, 0, 0);
    add(4'b1000, 1, 0, 0, 4'b1000, 0, 0, 0); // 18: off-only, no dead-time
    add(4'b1000, 1, 0, 0, 4'b1000, 0, 0, 0);
    add(4'b0001, 1, 0, 0, 4'b0000, 1, 0, 0); // 20
    add(4'b0001, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0001, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0001, 1, 0, 0, 4'b0001, 0, 0, 0);
    add(4'b0001, 1, 0, 0, 4'b0001, 0, 0, 0);
    add(4'b0010, 1, 0, 0, 4'b0000, 1, 0, 0); // 25: restart sequence N+1
    add(4'b0010, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0); // reload
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0100, 0, 0, 0); // 30: N+6
    add(4'b0100, 0, 0, 0, 4'b0000, 0, 0, 0); // disable
    add(4'b0100, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0100, 0, 0, 0);
    add(4'b0100, 0, 1, 0, 4'b0000, 0, 1, 0); // 37: fault beats disable
    add(4'b0100, 0, 0, 1, 4'b0000, 0, 0, 0); // clear while disabled -> IDLE
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 1, 0, 0, 4'b0100, 0, 0, 0);
    add(4'b0111, 1, 0, 0, 4'b0100, !PairChk, 0, PairChk); // 43: illegal low pair
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 0, PairChk);
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 0, PairChk);
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 0, PairChk);
    add(4'b0101, 1, 0, 0, 4'b0101, 0, 0, PairChk);
    add(4'b0101, 1, 0, 0, 4'b0101, 0, 0, PairChk);

    reset_n       = 1'b0;
    if3.phase_in  = 4'b0101;
    if3.enable    = 1'b1;
    if3.fault     = 1'b0;
    if3.fault_clr = 1'b0;
    if0.phase_in  = 4'b0101;
    if0.enable    = 1'b1;
    if0.fault     = 1'b0;
    if0.fault_clr = 1'b0;

    #22;
    check("reset phase_out", 32'(if3.phase_out), 32'h0);
    check("reset busy", 32'(if3.busy), 32'h0);
    check("reset fault_latched", 32'(if3.fault_latched), 32'h0);
    check("reset illegal", 32'(if3.illegal), 32'h0);
    check("reset dut0 phase_out", 32'(if0.phase_out), 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      if3.phase_in  = vecs[i].pi;
      if3.enable    = vecs[i].en;
      if3.fault     = vecs[i].flt;
      if3.fault_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("row%0d phase_out", i), 32'(if3.phase_out), 32'(vecs[i].po));
      check($sformatf("row%0d busy", i), 32'(if3.busy), 32'(vecs[i].bsy));
      check($sformatf("row%0d fault_latched", i), 32'(if3.fault_latched), 32'(vecs[i].fl));
      check($sformatf("row%0d illegal", i), 32'(if3.illegal), 32'(vecs[i].ill));
      @(negedge clk);
    end
    if3.fault_clr = 1'b0;

    // Asynchronous reset in the middle of a dead-time.
    if3.phase_in = 4'b1010;
    @(posedge clk);
    #1;
    check("middead busy", 32'(if3.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset phase_out", 32'(if3.phase_out), 32'h0);
    check("async reset busy", 32'(if3.busy), 32'h0);
    check("async reset illegal", 32'(if3.illegal), 32'h0);
    check("async reset fault_latched", 32'(if3.fault_latched), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (if3.busy === 1'b1) bcnt++;
      if (if3.phase_out === 4'b1010) lat = c;
    end
    check("post-reset latency", 32'(lat), 32'd4);
    check("post-reset busy cycles", 32'(bcnt), 32'd3);

    // Zero dead-time instance.
    check("dc0 hold", 32'(if0.phase_out), 32'h5);
    @(negedge clk);
    if0.phase_in = 4'b1010;
    @(posedge clk);
    #1;
    check("dc0 swap phase_out", 32'(if0.phase_out), 32'ha);
    check("dc0 swap busy", 32'(if0.busy), 32'h0);
    @(negedge clk);
    if0.fault = 1'b1;
    @(posedge clk);
    #1;
    check("dc0 fault phase_out", 32'(if0.phase_out), 32'h0);
    check("dc0 fault latched", 32'(if0.fault_latched), 32'h1);
    @(negedge clk);
    if0.fault     = 1'b0;
    if0.fault_clr = 1'b1;
    @(posedge clk);
    #1;
    check("dc0 clear phase_out", 32'(if0.phase_out), 32'ha);
    check("dc0 clear latched", 32'(if0.fault_latched), 32'h0);
    @(negedge clk);
    if0.fault_clr = 1'b0;
    @(negedge clk);
    check("dc0 busy never", 32'(busy0_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
